// File: rtl/uart_pkt_pkg.sv
// Shared constants and state encoding for the UART packet framer.
// Optional feature macro: UART_PKT_CHECKSUM_EN (adds the SEND_CSUM state).
package uart_pkt_pkg;

  // First byte of every packet on the wire.
  localparam logic [7:0] SYNC_BYTE = 8'h55;

  // Cycles from the fifo_re strobe to valid fifo_data.
  localparam int FIFO_RD_LATENCY = 2;

  typedef enum logic [3:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    RD_CAP,
    SEND_SYNC,
    SEND_LEN,
    SEND_DATA,
`ifdef UART_PKT_CHECKSUM_EN
    SEND_CSUM,
`endif
    WAIT_DONE
  } state_t;

endpackage

// File: rtl/uart_pkt_framer.sv
// Drains bytes from the decoder FIFO into a payload buffer and frames them
// for uart_tx as: SYNC, length, payload[0..n-1] (, XOR checksum).
// A packet goes out when the buffer is full or after IDLE_TIMEOUT cycles of
// an empty FIFO with a partial buffer.
// Optional feature macro: UART_PKT_CHECKSUM_EN (appends XOR of length+payload).
module uart_pkt_framer
  import uart_pkt_pkg::*;
#(
  parameter int MAX_PAYLOAD  = 16,
  parameter int IDLE_TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       fifo_empty,
  input  logic       fifo_we,
  input  logic [7:0] fifo_data,
  output logic       fifo_re,
  output logic       tx_dv,
  output logic [7:0] tx_byte,
  input  logic       tx_done,
  output logic       busy,
  output logic [15:0] pkt_count
);

  localparam int IDX_W  = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
  localparam int IC_W   = $clog2(IDLE_TIMEOUT + 1);
  localparam int PIPE_W = FIFO_RD_LATENCY - 1;

  localparam logic [7:0]      MAX_CNT = 8'(MAX_PAYLOAD);
  localparam logic [IC_W-1:0] IC_MAX  = IC_W'(IDLE_TIMEOUT);

  state_t            state_reg;
  state_t            state_next;
  state_t            last_sent_reg;   // which SEND_* state WAIT_DONE is waiting on
  logic [7:0]        count_reg;       // bytes buffered for the current packet
  logic [IC_W-1:0]   idle_cnt_reg;
  logic [7:0]        data_idx_reg;    // payload byte currently on the wire
  logic [7:0]        tx_byte_reg;
  logic [15:0]       pkt_count_reg;
  logic [PIPE_W-1:0] rd_pipe_reg;     // tracks the outstanding read strobe
  logic [7:0]        send_byte;
  logic              last_payload;
  logic              pkt_done;
  logic [7:0]        buffer_mem [MAX_PAYLOAD];
`ifdef UART_PKT_CHECKSUM_EN
  logic [7:0]        csum_reg;
`endif

  assign last_payload = (data_idx_reg == count_reg - 8'd1);
  assign busy         = (state_reg != IDLE);
  assign tx_byte      = send_byte;
  assign pkt_count    = pkt_count_reg;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state decode plus the strobes and the byte presented to uart_tx.
  always_comb begin
    state_next = state_reg;
    fifo_re    = 1'b0;
    tx_dv      = 1'b0;
    send_byte  = tx_byte_reg;
    pkt_done   = 1'b0;
    case (state_reg)
      IDLE: begin
        if ((count_reg == MAX_CNT) ||
            (count_reg != 8'd0 && idle_cnt_reg == IC_MAX)) begin
          state_next = SEND_SYNC;
        end else if (!fifo_empty && !fifo_we && count_reg < MAX_CNT) begin
          state_next = RD_REQ;
        end
      end
      RD_REQ: begin
        fifo_re    = 1'b1;
        state_next = RD_WAIT;
      end
      RD_WAIT: begin
        if (rd_pipe_reg[PIPE_W-1]) begin
          state_next = RD_CAP;
        end
      end
      RD_CAP: begin
        state_next = IDLE;
      end
      SEND_SYNC: begin
        tx_dv      = 1'b1;
        send_byte  = SYNC_BYTE;
        state_next = WAIT_DONE;
      end
      SEND_LEN: begin
        tx_dv      = 1'b1;
        send_byte  = count_reg;
        state_next = WAIT_DONE;
      end
      SEND_DATA: begin
        tx_dv      = 1'b1;
        send_byte  = buffer_mem[data_idx_reg[IDX_W-1:0]];
        state_next = WAIT_DONE;
      end
`ifdef UART_PKT_CHECKSUM_EN
      SEND_CSUM: begin
        tx_dv      = 1'b1;
        send_byte  = csum_reg;
        state_next = WAIT_DONE;
      end
`endif
      WAIT_DONE: begin
        if (tx_done) begin
          case (last_sent_reg)
            SEND_SYNC: state_next = SEND_LEN;
            SEND_LEN:  state_next = SEND_DATA;
            SEND_DATA: begin
              if (!last_payload) begin
                state_next = SEND_DATA;
              end else begin
`ifdef UART_PKT_CHECKSUM_EN
                state_next = SEND_CSUM;
`else
                state_next = IDLE;
                pkt_done   = 1'b1;
`endif
              end
            end
`ifdef UART_PKT_CHECKSUM_EN
            SEND_CSUM: begin
              state_next = IDLE;
              pkt_done   = 1'b1;
            end
`endif
            default: state_next = IDLE;
          endcase
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Packet bookkeeping: buffer fill level, idle timer, byte sequencing, counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg     <= 8'd0;
      idle_cnt_reg  <= '0;
      data_idx_reg  <= 8'd0;
      tx_byte_reg   <= 8'd0;
      pkt_count_reg <= 16'd0;
      last_sent_reg <= IDLE;
      rd_pipe_reg   <= '0;
`ifdef UART_PKT_CHECKSUM_EN
      csum_reg      <= 8'd0;
`endif
    end else begin
      rd_pipe_reg <= (rd_pipe_reg << 1) | PIPE_W'(fifo_re);

      if (state_reg == RD_CAP || count_reg == 8'd0) begin
        idle_cnt_reg <= '0;
      end else if (state_reg == IDLE && fifo_empty && idle_cnt_reg != IC_MAX) begin
        idle_cnt_reg <= idle_cnt_reg + 1'b1;
      end

      if (state_reg == RD_CAP) begin
        count_reg <= count_reg + 8'd1;
      end

      if (tx_dv) begin
        tx_byte_reg   <= send_byte;
        last_sent_reg <= state_reg;
      end

      if (state_reg == SEND_LEN) begin
        data_idx_reg <= 8'd0;
`ifdef UART_PKT_CHECKSUM_EN
        csum_reg     <= count_reg;
`endif
      end

`ifdef UART_PKT_CHECKSUM_EN
      if (state_reg == SEND_DATA) begin
        csum_reg <= csum_reg ^ send_byte;
      end
`endif

      if (state_reg == WAIT_DONE && tx_done &&
          last_sent_reg == SEND_DATA && !last_payload) begin
        data_idx_reg <= data_idx_reg + 8'd1;
      end

      if (pkt_done) begin
        count_reg     <= 8'd0;
        pkt_count_reg <= pkt_count_reg + 16'd1;
      end
    end
  end

  // Payload storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (state_reg == RD_CAP) begin
      buffer_mem[count_reg[IDX_W-1:0]] <= fifo_data;
    end
  end

endmodule

// File: tb/tb_uart_pkt_framer.sv
// Directed bench for uart_pkt_framer: FIFO model with 2-cycle read latency,
// uart_tx model with programmable byte time, and a wire monitor.
// Honours UART_PKT_CHECKSUM_EN when building expected packets.
module tb_uart_pkt_framer;

  logic        clk;
  logic        rst_n;
  logic        fifo_empty;
  logic        fifo_we;
  logic [7:0]  fifo_data;
  logic        fifo_re;
  logic        tx_dv;
  logic [7:0]  tx_byte;
  logic        tx_done;
  logic        busy;
  logic [15:0] pkt_count;

  int errors = 0;
  int checks = 0;

  uart_pkt_framer #(.MAX_PAYLOAD(16), .IDLE_TIMEOUT(1024)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fifo_empty (fifo_empty),
    .fifo_we    (fifo_we),
    .fifo_data  (fifo_data),
    .fifo_re    (fifo_re),
    .tx_dv      (tx_dv),
    .tx_byte    (tx_byte),
    .tx_done    (tx_done),
    .busy       (busy),
    .pkt_count  (pkt_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- FIFO model (data valid 2 cycles after fifo_re) --------
  logic [7:0] fifo_mem [256];
  logic [7:0] wr_ptr = 8'd0;
  logic [7:0] rd_ptr = 8'd0;
  logic [7:0] stage1 = 8'd0;
  logic       stage1_vld = 1'b0;

  assign fifo_empty = (wr_ptr == rd_ptr);

  initial fifo_data = 8'hEE;
  always @(posedge clk) begin
    stage1_vld <= 1'b0;
    fifo_data  <= 8'hEE;
    if (fifo_re) begin
      stage1     <= fifo_mem[rd_ptr];
      rd_ptr     <= rd_ptr + 8'd1;
      stage1_vld <= 1'b1;
    end
    if (stage1_vld) fifo_data <= stage1;
  end

  task automatic push(input logic [7:0] b);
    fifo_mem[wr_ptr] = b;
    wr_ptr = wr_ptr + 8'd1;
  endtask

  // ---------------- uart_tx model ----------------------------------------
  int tx_delay = 3;
  int tx_cnt;
  logic tx_active;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_done   <= 1'b0;
      tx_active <= 1'b0;
      tx_cnt    <= 0;
    end else begin
      tx_done <= 1'b0;
      if (tx_dv) begin
        tx_active <= 1'b1;
        tx_cnt    <= tx_delay;
      end else if (tx_active) begin
        if (tx_cnt <= 1) begin
          tx_done   <= 1'b1;
          tx_active <= 1'b0;
        end else begin
          tx_cnt <= tx_cnt - 1;
        end
      end
    end
  end

  // ---------------- wire monitor -----------------------------------------
  logic [7:0] rx_q [$];
  logic [7:0] held;
  logic       holding = 1'b0;
  logic       prev_dv = 1'b0;
  int         re_count = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      holding = 1'b0;
      prev_dv = 1'b0;
    end else begin
      if (tx_dv) begin
        checks++;
        assert (prev_dv === 1'b0) else begin
          errors++;
          $error("FAIL tx_dv_width observed=multi-cycle expected=single-cycle");
        end
        rx_q.push_back(tx_byte);
        held    = tx_byte;
        holding = 1'b1;
      end else if (holding) begin
        checks++;
        assert (tx_byte === held) else begin
          errors++;
          $error("FAIL tx_byte_hold observed=0x%0h expected=0x%0h", tx_byte, held);
        end
      end
      checks++;
      assert (!(fifo_re && holding)) else begin
        errors++;
        $error("FAIL read_during_tx observed=fifo_re=1 expected=fifo_re=0");
      end
      if (tx_done && !tx_dv) holding = 1'b0;
      if (fifo_re) re_count++;
      prev_dv = tx_dv;
    end
  end

  // ---------------- checking helpers ---------------------------------------
  logic [7:0] pl_q [$];

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_pkt(input string tag, input int bound, input logic [15:0] exp_pkts);
    logic [7:0] exp_q [$];
    logic [7:0] x;
    logic [7:0] obs;
    exp_q.push_back(8'h55);
    x = 8'(pl_q.size());
    exp_q.push_back(x);
    foreach (pl_q[i]) begin
      exp_q.push_back(pl_q[i]);
      x = x ^ pl_q[i];
    end
`ifdef UART_PKT_CHECKSUM_EN
    exp_q.push_back(x);
`endif
    for (int i = 0; i < bound; i++) begin
      if (rx_q.size() >= exp_q.size() && !busy) break;
      @(negedge clk);
    end
    repeat (4) @(negedge clk);
    check({tag, "_nbytes"}, 16'(rx_q.size()), 16'(exp_q.size()));
    foreach (exp_q[i]) begin
      obs = (i < rx_q.size()) ? rx_q[i] : 8'h00;
      check($sformatf("%s_byte%0d", tag, i), {8'h00, obs}, {8'h00, exp_q[i]});
    end
    check({tag, "_pkt_count"}, pkt_count, exp_pkts);
    $display("pkt %s: %0d bytes on wire, pkt_count=%0d", tag, rx_q.size(), pkt_count);
    rx_q.delete();
    pl_q.delete();
  endtask

  // ---------------- directed sequence ---------------------------------------
  int r0;
  initial begin
    rst_n   = 1'b0;
    fifo_we = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_fifo_re",   {15'd0, fifo_re}, 16'd0);
    check("rst_tx_dv",     {15'd0, tx_dv},   16'd0);
    check("rst_tx_byte",   {8'd0, tx_byte},  16'd0);
    check("rst_busy",      {15'd0, busy},    16'd0);
    check("rst_pkt_count", pkt_count,        16'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Partial packet flushed only after the idle timeout.
    tx_delay = 3;
    push(8'h11); push(8'h22); push(8'h33);
    pl_q = {8'h11, 8'h22, 8'h33};
    repeat (500) @(negedge clk);
    check("A_no_early_tx", 16'(rx_q.size()), 16'd0);
    check("A_reads",       16'(re_count),     16'd3);
    expect_pkt("A", 3000, 16'd1);

    // Full buffer sends at once; the 17th byte must wait in the FIFO.
    for (int i = 0; i < 17; i++) push(8'(i));
    for (int i = 0; i < 16; i++) pl_q.push_back(8'(i));
    expect_pkt("B_full", 300, 16'd2);
    pl_q = {8'h10};
    expect_pkt("B_tail", 3000, 16'd3);

    // Writer activity blocks reads.
    fifo_we = 1'b1;
    r0 = re_count;
    push(8'hAA); push(8'hBB);
    repeat (50) @(negedge clk);
    check("C_we_blocks_re", 16'(re_count - r0), 16'd0);
    check("C_fifo_re_low",  {15'd0, fifo_re},   16'd0);
    fifo_we = 1'b0;
    for (int i = 0; i < 50 && (re_count - r0) < 2; i++) @(negedge clk);
    check("C_reads_after_we", 16'(re_count - r0), 16'd2);
    pl_q = {8'hAA, 8'hBB};
    expect_pkt("C", 3000, 16'd4);

    // Slow transmitter: byte held stable, one tx_dv per byte.
    tx_delay = 400;
    push(8'h5A); push(8'hC3); push(8'h7E);
    pl_q = {8'h5A, 8'hC3, 8'h7E};
    expect_pkt("D_slow", 6000, 16'd5);

    // Reset during the first payload byte.
    tx_delay = 20;
    push(8'h01); push(8'h02);
    for (int i = 0; i < 3000 && rx_q.size() < 3; i++) @(negedge clk);
    check("E_reached_payload", 16'(rx_q.size()), 16'd3);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("E_rst_tx_dv",     {15'd0, tx_dv},   16'd0);
    check("E_rst_busy",      {15'd0, busy},    16'd0);
    check("E_rst_tx_byte",   {8'd0, tx_byte},  16'd0);
    check("E_rst_fifo_re",   {15'd0, fifo_re}, 16'd0);
    check("E_rst_pkt_count", pkt_count,        16'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    rx_q.delete();
    @(negedge clk);
    push(8'h77);
    pl_q = {8'h77};
    expect_pkt("E_after_rst", 3000, 16'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
